// File: rtl/ai_collision_sensor.sv
// ai_collision_sensor: per-frame proximity flags with hold, contact counting and a start-of-race grace period
module ai_collision_sensor #(
    parameter int CAR_W        = 47,
    parameter int CAR_L        = 67,
    parameter int ROAD_X_MIN   = 325,
    parameter int ROAD_X_MAX   = 495,
    parameter int LOOK_AHEAD   = 120,
    parameter int SIDE_MARGIN  = 8,
    parameter int WALL_MARGIN  = 4,
    parameter int HOLD_FRAMES  = 8,
    parameter int GRACE_FRAMES = 30
) (
    input  logic        frame_clk,
    input  logic        Reset_n,
    input  logic        GameStart,
    input  logic [9:0]  AIX,
    input  logic [9:0]  PlayerX,
    input  logic [15:0] TarDistance,
    output logic [3:0]  AICollide,
    output logic        Contact,
    output logic [7:0]  ContactCount,
    output logic        SensorActive
);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam int GW = $clog2(GRACE_FRAMES + 1);
    localparam logic [10:0]        L_W    = 11'(CAR_W);
    localparam logic [10:0]        L_WMIN = 11'(ROAD_X_MIN + WALL_MARGIN);
    localparam logic [10:0]        L_WMAX = 11'(ROAD_X_MAX - WALL_MARGIN);
    localparam logic [10:0]        L_SM   = 11'(SIDE_MARGIN);
    localparam logic signed [16:0] L_LA   = 17'(LOOK_AHEAD);
    localparam logic signed [16:0] L_CL   = 17'(CAR_L);
    localparam logic signed [16:0] L_Z    = 17'sd0;

    typedef enum logic [1:0] {IDLE, GRACE, ACTIVE} state_t;

    state_t             r_state, w_next;
    logic [GW-1:0]      r_grace;
    logic [HW-1:0]      r_hold [4];
    logic               r_contact;
    logic [7:0]         r_count;
    logic [10:0]        w_ax, w_px, w_ax_r, w_px_r;
    logic signed [16:0] w_d, w_gap, w_abs;
    logic               w_lat, w_lon, w_sense;
    logic [4:0]         w_raw;

    assign w_ax   = {1'b0, AIX};
    assign w_px   = {1'b0, PlayerX};
    assign w_ax_r = w_ax + L_W;
    assign w_px_r = w_px + L_W;
    assign w_d    = {TarDistance[15], TarDistance};
    assign w_gap  = -w_d;
    assign w_abs  = (w_d < L_Z) ? w_gap : w_d;
    assign w_lat  = (w_ax < w_px_r) && (w_px < w_ax_r);
    assign w_lon  = w_abs < L_CL;
    // Sensing covers the edge that enters ACTIVE, so the first sensed sample lands with SensorActive rising
    assign w_sense = (w_next == ACTIVE);

    // Raw proximity conditions, forced low outside sensing
    always_comb begin
        w_raw    = '0;
        w_raw[0] = w_sense && w_lat && (w_gap > L_Z) && (w_gap <= L_LA);
        w_raw[1] = w_sense && w_lat && (w_d > L_Z) && (w_d <= L_LA);
        w_raw[2] = w_sense && ((w_ax < L_WMIN) ||
                   (w_lon && (w_px_r <= w_ax) && ((w_ax - w_px_r) < L_SM)));
        w_raw[3] = w_sense && ((w_ax_r > L_WMAX) ||
                   (w_lon && (w_ax_r <= w_px) && ((w_px - w_ax_r) < L_SM)));
        w_raw[4] = w_sense && w_lat && w_lon;
    end

    // Next-state: GameStart low always returns to IDLE; grace expiry enters ACTIVE
    always_comb begin
        w_next = r_state;
        if (!GameStart)
            w_next = IDLE;
        else if (r_state == IDLE)
            w_next = GRACE;
        else if (r_state == GRACE && r_grace == '0)
            w_next = ACTIVE;
    end

    // State, grace countdown, registered contact and saturating contact-event count
    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            r_state   <= IDLE;
            r_grace   <= '0;
            r_contact <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_next;
            r_grace   <= (r_state == IDLE && w_next == GRACE) ? GW'(GRACE_FRAMES) :
                         (w_next == GRACE && r_grace != '0) ? r_grace - GW'(1) : '0;
            r_contact <= w_raw[4];
            if (r_state == IDLE && GameStart)
                r_count <= '0;
            else if (w_raw[4] && !r_contact && r_count != 8'hFF)
                r_count <= r_count + 8'd1;
        end
    end

    // Per-bit hold counters: reload on raw, otherwise count down to zero
    always_ff @(posedge frame_clk) begin
        for (int i = 0; i < 4; i++)
            if (!Reset_n || !GameStart)
                r_hold[i] <= '0;
            else
                r_hold[i] <= w_raw[i] ? HW'(HOLD_FRAMES) :
                             (r_hold[i] != '0) ? r_hold[i] - HW'(1) : '0;
    end

    // Flags are high while their hold counter is nonzero
    always_comb begin
        AICollide = '0;
        for (int i = 0; i < 4; i++)
            AICollide[i] = (r_hold[i] != '0);
    end

    assign Contact      = r_contact;
    assign ContactCount = r_count;
    assign SensorActive = (r_state == ACTIVE);
endmodule

// File: tb/tb_ai_collision_sensor.sv
// tb_ai_collision_sensor: directed and random stimulus checked against a frame-level reference model
module tb_ai_collision_sensor;
    localparam int W = 47, L = 67, XMIN = 325, XMAX = 495, LA = 120, SM = 8, WM = 4, H = 8, G = 30;

    logic        clk = 1'b0, rst_n = 1'b0, gs = 1'b0;
    logic [9:0]  aix = 10'd336, px = 10'd336;
    logic [15:0] td = '0;
    logic [3:0]  col;
    logic        con, act;
    logic [7:0]  cnt;

    int total = 0, passed = 0, failed = 0;
    int edge_no = 0, run = 0, m_cnt = 0, c0 = 0;
    bit m_con = 0;
    int last [4] = '{-1000, -1000, -1000, -1000};

    ai_collision_sensor dut (
        .frame_clk(clk), .Reset_n(rst_n), .GameStart(gs), .AIX(aix), .PlayerX(px),
        .TarDistance(td), .AICollide(col), .Contact(con), .ContactCount(cnt), .SensorActive(act)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Spec-level raw conditions in plain integer arithmetic: {C, right, left, rear, front}
    function automatic logic [4:0] raw(input int a, input int p, input int d);
        int gap;
        bit lat, lon;
        gap = -d;
        lat = (a < p + W) && (p < a + W);
        lon = ((d < 0) ? -d : d) < L;
        raw[0] = lat && gap > 0 && gap <= LA;
        raw[1] = lat && -gap > 0 && -gap <= LA;
        raw[2] = (a < XMIN + WM) || (lon && p + W <= a && a - (p + W) < SM);
        raw[3] = (a + W > XMAX - WM) || (lon && a + W <= p && p - (a + W) < SM);
        raw[4] = lat && lon;
    endfunction

    task automatic tick();
        logic [4:0] r;
        logic [3:0] e;
        int d;
        @(posedge clk);
        edge_no++;
        d = int'($signed(td));
        if (!rst_n || !gs) begin
            if (!rst_n) m_cnt = 0;
            run = 0;
            m_con = 0;
            for (int i = 0; i < 4; i++) last[i] = -1000;
        end else begin
            run++;
            if (run == 1) m_cnt = 0;
            r = (run >= G + 2) ? raw(int'(aix), int'(px), d) : 5'b0;
            for (int i = 0; i < 4; i++) if (r[i]) last[i] = edge_no;
            if (r[4] && !m_con && m_cnt < 255) m_cnt++;
            m_con = r[4];
        end
        #1;
        for (int i = 0; i < 4; i++) e[i] = (edge_no - last[i]) < H;
        chk("model_col", 16'(col), 16'(e));
        chk("model_contact", 16'(con), 16'(m_con));
        chk("model_count", 16'(cnt), 16'(m_cnt));
        chk("model_active", 16'(act), 16'(run >= G + 2));
    endtask

    initial begin
        gs = 1'b1; rst_n = 1'b0; td = 16'(-50);
        repeat (2) tick();
        chk("rst_col", 16'(col), 16'd0);
        chk("rst_cnt", 16'(cnt), 16'd0);
        chk("rst_act", 16'(act), 16'd0);
        rst_n = 1'b1;
        repeat (31) begin
            tick();
            chk("grace_act", 16'(act), 16'd0);
            chk("grace_col", 16'(col), 16'd0);
        end
        tick();
        chk("act_rise", 16'(act), 16'd1);
        chk("front_first", 16'(col[0]), 16'd1);
        chk("contact_first", 16'(con), 16'd1);
        td = 16'(-120); tick();
        chk("front_120", 16'(col[0]), 16'd1);
        td = 16'(-121); repeat (9) tick();
        chk("front_121", 16'(col[0]), 16'd0);
        td = 16'(60); tick();
        chk("rear_60", 16'(col[1]), 16'd1);
        td = 16'(1000); repeat (9) tick();
        chk("clear", 16'(col), 16'd0);
        td = 16'(-100); tick(); td = 16'(1000);
        repeat (7) begin tick(); chk("hold_on", 16'(col[0]), 16'd1); end
        tick();
        chk("hold_off", 16'(col[0]), 16'd0);
        td = 16'(-100); tick(); td = 16'(1000);
        repeat (4) begin tick(); chk("hold_pre", 16'(col[0]), 16'd1); end
        td = 16'(-100); tick(); td = 16'(1000);
        repeat (7) begin tick(); chk("hold_ext", 16'(col[0]), 16'd1); end
        tick();
        chk("hold_ext_off", 16'(col[0]), 16'd0);
        aix = 10'd328; px = 10'd700; tick();
        chk("wall_left", 16'(col[2]), 16'd1);
        aix = 10'd445; tick();
        chk("wall_right", 16'(col[3]), 16'd1);
        aix = 10'd340; px = 10'd395; td = 16'(10); repeat (9) tick();
        chk("side_gap8", 16'(col[3]), 16'd0);
        px = 10'd394; tick();
        chk("side_gap7", 16'(col[3]), 16'd1);
        aix = 10'd336; px = 10'd336; td = 16'(1000); tick();
        c0 = m_cnt;
        td = 16'(0); repeat (3) tick(); td = 16'(1000); tick();
        chk("cnt_one", 16'(cnt), 16'(c0 + 1));
        repeat (300) begin td = 16'(0); repeat (3) tick(); td = 16'(1000); tick(); end
        chk("cnt_sat", 16'(cnt), 16'd255);
        gs = 1'b0; tick(); gs = 1'b1;
        repeat (32) tick();
        repeat (7) begin td = 16'(0); repeat (3) tick(); td = 16'(1000); tick(); end
        td = 16'(-100); tick();
        chk("stop_pre_cnt", 16'(cnt), 16'd7);
        chk("stop_pre_col", 16'(col[0]), 16'd1);
        gs = 1'b0; tick();
        chk("stop_col", 16'(col), 16'd0);
        chk("stop_con", 16'(con), 16'd0);
        chk("stop_act", 16'(act), 16'd0);
        chk("stop_cnt", 16'(cnt), 16'd7);
        gs = 1'b1; tick();
        chk("restart_cnt", 16'(cnt), 16'd0);
        repeat (30) begin tick(); chk("regrace_act", 16'(act), 16'd0); end
        tick();
        chk("regrace_rise", 16'(act), 16'd1);
        repeat (600) begin
            aix   = 10'($urandom_range(300, 520));
            px    = 10'(int'(aix) + int'($urandom_range(0, 120)) - 60);
            td    = 16'(int'($urandom_range(0, 400)) - 200);
            gs    = ($urandom_range(0, 99) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ai_collision_sensor.md
# ai_collision_sensor

Per-frame proximity sensor that produces the 4-bit `AICollide` vector consumed by the AI car controller. It compares the AI car's lane position and race distance against the player car and the road edges, and raises blocking flags that persist for a programmable number of frames. It also reports bounding-box contact and keeps a saturating contact count. The block gates all sensing behind a start-of-race grace period.

## Interface
Parameters:
- `CAR_W`, 47, car width in pixels
- `CAR_L`, 67, car length in distance units
- `ROAD_X_MIN`, 325, leftmost legal car X
- `ROAD_X_MAX`, 495, rightmost legal car X (right edge)
- `LOOK_AHEAD`, 120, forward sensing window
- `SIDE_MARGIN`, 8, lateral gap treated as blocked
- `WALL_MARGIN`, 4, wall proximity treated as blocked
- `HOLD_FRAMES`, 8, flag persistence in frames (≥1)
- `GRACE_FRAMES`, 30, frames after start with sensing disabled (≥1)

Ports:
- `frame_clk` in 1: the single clock; one edge per video frame
- `Reset_n` in 1: synchronous, active-low reset
- `GameStart` in 1: race running; low returns the block to IDLE
- `AIX` in 10: AI car left X
- `PlayerX` in 10: player car left X
- `TarDistance` in 16: signed distance, AI minus player; positive means the AI is ahead
- `AICollide` out 4: [0] front blocked, [1] rear threat, [2] left blocked, [3] right blocked
- `Contact` out 1: bounding boxes intersect
- `ContactCount` out 8: number of contact events, saturating
- `SensorActive` out 1: state is ACTIVE

## Operation
- All arithmetic is done at 11/17 bits, so there is no wrap.
- `gap = -sext(TarDistance)` at 17 bits. A positive `gap` means the player is ahead of the AI.
- `latOv = (AIX < PlayerX+CAR_W) && (PlayerX < AIX+CAR_W)`
- `lonOv = |TarDistance| < CAR_L`
- Raw conditions, evaluated only in ACTIVE (forced 0 otherwise):
  - raw0: `latOv && 0 < gap <= LOOK_AHEAD`
  - raw1: `latOv && 0 < -gap <= LOOK_AHEAD`
  - raw2: `AIX < ROAD_X_MIN+WALL_MARGIN`, or (`lonOv && PlayerX+CAR_W <= AIX && AIX-(PlayerX+CAR_W) < SIDE_MARGIN`)
  - raw3: `AIX+CAR_W > ROAD_X_MAX-WALL_MARGIN`, or (`lonOv && AIX+CAR_W <= PlayerX && PlayerX-(AIX+CAR_W) < SIDE_MARGIN`)
  - rawC: `latOv && lonOv`
- Each bit i has a hold counter `hc[i]`:
  - raw high: load `HOLD_FRAMES`
  - else, if nonzero: decrement
  - `AICollide[i] = (hc[i] != 0)`
- `Contact` is rawC, registered.
- `ContactCount` increments on each 0→1 transition of `Contact` and saturates at 255.
- State machine:
  - IDLE: all flags, hold counters and `Contact` are 0. On `GameStart`=1: go to GRACE, load the grace counter with `GRACE_FRAMES`, and clear `ContactCount`.
  - GRACE: decrement the grace counter each edge. When it reaches 0: go to ACTIVE.
  - ACTIVE: sensing is enabled.
  - From any state, `GameStart`=0 sends the next state to IDLE and clears flags, hold counters and `Contact`. `ContactCount` holds its value.

## Timing
- Reset (`Reset_n`=0 at an edge):
  - state IDLE
  - `AICollide`=0, `Contact`=0, `ContactCount`=0, `SensorActive`=0
  - all counters 0
- Reset overrides `GameStart` and any in-progress hold or grace count.
- Raw conditions sampled at edge n appear on the outputs after edge n. This is one frame of latency.
- The grace period follows the `GameStart` edges:
  - `GameStart` is first seen high at edge k.
  - `SensorActive` rises after edge k+`GRACE_FRAMES`+1.
  - The first sensed inputs are sampled at edge k+`GRACE_FRAMES`+1.
- Hold timing: if a raw condition is last high at edge n, its flag stays high through edge n+`HOLD_FRAMES`-1 and is low after edge n+`HOLD_FRAMES`.
- If a raw condition reasserts during a hold, the counter reloads. The flag has no gap.
- Simultaneous conditions are allowed: raw0 and raw2/raw3 may be high together. Bits are independent.
- A `Contact` pulse that stays high for several frames counts as one event.

## Test plan
- Reset and grace:
  - Stimulus: `Reset_n`=0 for 2 edges, then `GameStart`=1 with `AIX`=`PlayerX`=336 and `TarDistance`=-50.
  - Required: `AICollide`=0 and `SensorActive`=0 for 31 edges. Then `SensorActive`=1, and `AICollide[0]`=1 and `Contact`=1 one edge later.
- Front window:
  - Stimulus: ACTIVE, `AIX`=`PlayerX`=336, `TarDistance`=-120, then -121.
  - Required: `AICollide[0]`=1 for -120; a fresh run at -121 gives 0. At `TarDistance`=+60, bit [1]=1.
- Hold expiry:
  - Stimulus: raw0 high for one edge, then cleared.
  - Required: bit [0] is high for exactly 8 frames, then low. Reasserting it at frame 5 extends the flag with no gap.
- Walls and side:
  - Stimulus: `AIX`=328, then `AIX`=445.
  - Required: `AIX`=328 gives `AICollide[2]`=1. `AIX`=445 gives `AICollide[3]`=1.
  - Stimulus: `PlayerX`=395, `AIX`=340, `TarDistance`=10 (gap 8, so not blocked) → bit [3]=0. With `PlayerX`=394 (gap 7) → bit [3]=1.
- Contact counting:
  - Stimulus: 300 separate overlap pulses of 3 frames each.
  - Required: `ContactCount` stops at 255. A single 3-frame pulse adds exactly 1.
- Mid-race stop:
  - Stimulus: `GameStart`=0 while flags are held and `ContactCount`=7.
  - Required: next edge gives `AICollide`=0, `Contact`=0, `SensorActive`=0, `ContactCount`=7.
  - Stimulus: `GameStart` reasserted.
  - Required: `ContactCount`=0 and the grace period restarts.
